aes_key_expand: RTL and testbench

//  AES-128 key schedule generator. Loads a 128-bit cipher key and emits the 11 round keys (round 0..10),
//  one per accepted cycle, for the round datapath. SubWord uses four instances of the team's Sbox byte lookup.

---
 rtl/aes_key_expand.sv | 185 ++++++++++++++++++
 tb/tb_aes_key_expand.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/aes_key_expand.sv
// AES-128 key schedule: loads a cipher key and emits round keys 0..10, one per accepted cycle.
// Optional consumer back-pressure (rk_ready port) is enabled by defining AES_KEY_STALL_EN.

module aes_sbox #(
  parameter int BYTE = 8
) (
  input  logic [BYTE-1:0] i_byte,
  output logic [BYTE-1:0] o_byte
);

  // Byte n of the forward S-box lives at bits [(255-n)*8 +: 8].
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [BYTE+2:0] w_bit_idx;

  assign w_bit_idx = {~i_byte, 3'b000};
  assign o_byte    = SBOX_TABLE[w_bit_idx +: 8];

endmodule

module aes_key_expand #(
  parameter int BYTE   = 8,
  parameter int DWORD  = 32,
  parameter int LENGTH = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LENGTH-1:0] key_in,
`ifdef AES_KEY_STALL_EN
  input  logic              rk_ready,
`endif
  output logic [LENGTH-1:0] round_key,
  output logic [3:0]        round_idx,
  output logic              rk_valid,
  output logic              busy,
  output logic              done
);

  typedef enum logic {
    S_IDLE,
    S_EXPAND
  } state_t;

  localparam logic [3:0] LAST_ROUND = 4'd10;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [LENGTH-1:0] r_round_key;
  logic [LENGTH-1:0] w_round_key_nxt;
  logic [3:0]        r_round_idx;
  logic [3:0]        w_round_idx_nxt;
  logic              r_rk_valid;
  logic              w_rk_valid_nxt;
  logic              r_busy;
  logic              w_busy_nxt;
  logic [BYTE-1:0]   r_rcon;
  logic [BYTE-1:0]   w_rcon_nxt;

  logic              w_ready;
  logic              w_accept;
  logic              w_done;
  logic [DWORD-1:0]  w_w0, w_w1, w_w2, w_w3;
  logic [DWORD-1:0]  w_rot;
  logic [DWORD-1:0]  w_sub;
  logic [DWORD-1:0]  w_t;
  logic [DWORD-1:0]  w_n0, w_n1, w_n2, w_n3;
  logic [LENGTH-1:0] w_next_key;

  function automatic logic [BYTE-1:0] xtime(input logic [BYTE-1:0] x);
    xtime = {x[BYTE-2:0], 1'b0} ^ (x[BYTE-1] ? 8'h1b : 8'h00);
  endfunction

`ifdef AES_KEY_STALL_EN
  assign w_ready = rk_ready;
`else
  assign w_ready = 1'b1;
`endif

  assign w_accept = r_rk_valid & w_ready;

  // Next round key derived from the one currently presented.
  assign {w_w0, w_w1, w_w2, w_w3} = r_round_key;
  assign w_rot = {w_w3[DWORD-BYTE-1:0], w_w3[DWORD-1:DWORD-BYTE]};

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_sbox
      aes_sbox #(
        .BYTE(BYTE)
      ) u_sbox (
        .i_byte(w_rot[g*BYTE +: BYTE]),
        .o_byte(w_sub[g*BYTE +: BYTE])
      );
    end
  endgenerate

  assign w_t        = w_sub ^ {r_rcon, {(DWORD-BYTE){1'b0}}};
  assign w_n0       = w_w0 ^ w_t;
  assign w_n1       = w_w1 ^ w_n0;
  assign w_n2       = w_w2 ^ w_n1;
  assign w_n3       = w_w3 ^ w_n2;
  assign w_next_key = {w_n0, w_n1, w_n2, w_n3};

  always_comb begin
    w_state_nxt     = r_state;
    w_round_key_nxt = r_round_key;
    w_round_idx_nxt = r_round_idx;
    w_rk_valid_nxt  = r_rk_valid;
    w_busy_nxt      = r_busy;
    w_rcon_nxt      = r_rcon;
    w_done          = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt     = S_EXPAND;
          w_round_key_nxt = key_in;
          w_round_idx_nxt = 4'd0;
          w_rk_valid_nxt  = 1'b1;
          w_busy_nxt      = 1'b1;
          w_rcon_nxt      = 8'h01;
        end
      end
      S_EXPAND: begin
        if (w_accept) begin
          if (r_round_idx == LAST_ROUND) begin
            // Final round key stays on the bus after the schedule ends.
            w_done          = 1'b1;
            w_state_nxt     = S_IDLE;
            w_round_idx_nxt = 4'd0;
            w_rk_valid_nxt  = 1'b0;
            w_busy_nxt      = 1'b0;
          end else begin
            w_round_key_nxt = w_next_key;
            w_round_idx_nxt = r_round_idx + 4'd1;
            w_rcon_nxt      = xtime(r_rcon);
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_round_key <= '0;
      r_round_idx <= 4'd0;
      r_rk_valid  <= 1'b0;
      r_busy      <= 1'b0;
      r_rcon      <= 8'h01;
    end else begin
      r_state     <= w_state_nxt;
      r_round_key <= w_round_key_nxt;
      r_round_idx <= w_round_idx_nxt;
      r_rk_valid  <= w_rk_valid_nxt;
      r_busy      <= w_busy_nxt;
      r_rcon      <= w_rcon_nxt;
    end
  end

  assign round_key = r_round_key;
  assign round_idx = r_round_idx;
  assign rk_valid  = r_rk_valid;
  assign busy      = r_busy;
  assign done      = w_done;

endmodule

// File: tb/tb_aes_key_expand.sv
// Directed bench for aes_key_expand: FIPS-197 and all-zero key schedules, ignored starts,
// mid-schedule reset, back-to-back schedules and (with AES_KEY_STALL_EN) consumer stalls.

module tb_aes_key_expand;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [127:0] key_in = '0;
`ifdef AES_KEY_STALL_EN
  logic         rk_ready = 1'b1;
`endif
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         rk_valid;
  logic         busy;
  logic         done;

  localparam logic [127:0] FIPS_RK [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };
  localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic [127:0] got [0:10];
  int           n_chk  = 0;
  int           n_fail = 0;
  int           cyc;

  aes_key_expand #(
    .BYTE(8),
    .DWORD(32),
    .LENGTH(128)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .key_in(key_in),
`ifdef AES_KEY_STALL_EN
    .rk_ready(rk_ready),
`endif
    .round_key(round_key),
    .round_idx(round_idx),
    .rk_valid(rk_valid),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got %0t required < 400000", $time);
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Assert start for one cycle; returns at the negedge where round 0 is visible.
  task automatic start_key(input logic [127:0] k);
    start  = 1'b1;
    key_in = k;
    @(negedge clk);
    start  = 1'b0;
    key_in = ~k;
  endtask

  // Walk one schedule from round 0, optionally pulsing start with another key at round
  // inj_at, and optionally stalling stall_len cycles at round stall_at.
  task automatic collect(input int inj_at, input logic [127:0] inj_key,
                         input int stall_at, input int stall_len);
    cyc = 0;
    for (int k = 0; k <= 10; k++) begin
      check_eq("round_idx", {124'd0, round_idx}, k);
      check_eq("rk_valid", {127'd0, rk_valid}, 1);
      check_eq("busy", {127'd0, busy}, 1);
`ifdef AES_KEY_STALL_EN
      if (k == stall_at) begin
        rk_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          check_eq("done_stall", {127'd0, done}, 0);
          @(negedge clk);
          cyc++;
          check_eq("idx_stall", {124'd0, round_idx}, k);
          check_eq("valid_stall", {127'd0, rk_valid}, 1);
        end
        rk_ready = 1'b1;
      end
`endif
      got[k] = round_key;
      if (k == inj_at) begin
        start  = 1'b1;
        key_in = inj_key;
      end
      check_eq("done", {127'd0, done}, (k == 10) ? 1 : 0);
      @(negedge clk);
      cyc++;
      start = 1'b0;
    end
    check_eq("busy_end", {127'd0, busy}, 0);
    check_eq("valid_end", {127'd0, rk_valid}, 0);
    check_eq("done_end", {127'd0, done}, 0);
    check_eq("idx_end", {124'd0, round_idx}, 0);
  endtask

  task automatic check_fips(input string tag);
    for (int k = 0; k <= 10; k++) check_eq(tag, got[k], FIPS_RK[k]);
  endtask

  initial begin
    // Reset state
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_key", round_key, 0);
    check_eq("rst_idx", {124'd0, round_idx}, 0);
    check_eq("rst_valid", {127'd0, rk_valid}, 0);
    check_eq("rst_busy", {127'd0, busy}, 0);
    check_eq("rst_done", {127'd0, done}, 0);
    rst = 1'b0;
    @(negedge clk);

    // FIPS-197 key, full schedule
    start_key(FIPS_RK[0]);
    collect(-1, '0, -1, 0);
    check_fips("fips_rk");
    check_eq("fips_cycles", cyc, 11);

    // Back-to-back: start in the cycle busy has fallen, all-zero key
    start_key('0);
    collect(-1, '0, -1, 0);
    check_eq("zero_rk0", got[0], 0);
    check_eq("zero_rk1", got[1], ZERO_RK1);
    check_eq("zero_rk10", got[10], ZERO_RK10);

    // Start pulsed mid-schedule with a different key is ignored
    start_key(FIPS_RK[0]);
    collect(4, '0, -1, 0);
    check_fips("inj4_rk");

    // Start coincident with the final accept is ignored
    start_key(FIPS_RK[0]);
    collect(10, '0, -1, 0);
    check_fips("inj10_rk");
    @(negedge clk);
    check_eq("inj10_idle_valid", {127'd0, rk_valid}, 0);
    check_eq("inj10_idle_busy", {127'd0, busy}, 0);

    // Asynchronous reset at round 6
    start_key(FIPS_RK[0]);
    for (int k = 0; k < 6; k++) @(negedge clk);
    check_eq("pre_rst_idx", {124'd0, round_idx}, 6);
    check_eq("pre_rst_key", round_key, FIPS_RK[6]);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_key", round_key, 0);
    check_eq("arst_idx", {124'd0, round_idx}, 0);
    check_eq("arst_valid", {127'd0, rk_valid}, 0);
    check_eq("arst_busy", {127'd0, busy}, 0);
    check_eq("arst_done", {127'd0, done}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_busy", {127'd0, busy}, 0);
    start_key(FIPS_RK[0]);
    collect(-1, '0, -1, 0);
    check_fips("post_rst_rk");

`ifdef AES_KEY_STALL_EN
    // Consumer stall of 3 cycles at round 2
    start_key(FIPS_RK[0]);
    collect(-1, '0, 2, 3);
    check_fips("stall_rk");
    check_eq("stall_cycles", cyc, 14);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
